mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter RR_ENABLE, default 1; 1 selects round-robin arbitration, 0 selects fixed priority with requester 0 winning.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state on posedge), then rst input 1.
REQ-003 The block SHALL provide these ports per requester n (n = 0, 1):
- req_valid_n, input, 1: request pending.
- req_ready_n, output, 1: request accepted this cycle.
- req_we_n, input, 1: 1 = store, 0 = load.
- req_size_n, input, 2: 00 byte, 01 half, 10 or 11 word.
- req_addr_n, input, 32: byte address.
- req_wdata_n, input, 32: store data, right-aligned.
- resp_valid_n, output, 1: one-cycle completion pulse.
- resp_rdata_n, output, 32: load data, zero-extended.
REQ-004 The block SHALL provide these memory-side ports:
- mem_enable, output, 1.
- mem_addr, output, 32.
- mem_write_enable, output, 1.
- mem_data_in, output, 32.
- mem_data_out_v, input, 1.
- mem_data_out, input, 32: big-endian word starting at mem_addr; valid the cycle after a read enable.

Function
REQ-005 The FSM SHALL have states IDLE, ISSUE, MERGE and RESP, and SHALL start transactions only from IDLE.
REQ-006 In IDLE with any req_valid_n high, the block SHALL assert req_ready of exactly one granted requester, combinationally, and SHALL latch its we/size/addr/wdata and the requester id.
- Transition: IDLE -> ISSUE.
REQ-007 Grant SHALL be given to the only valid requester; if both are valid and RR_ENABLE=1, grant goes to the requester not granted last; if both are valid and RR_ENABLE=0, grant goes to requester 0.
REQ-008 The last-grant register SHALL update only on acceptance and SHALL reset to 1, so requester 0 wins the first contention.
REQ-009 In ISSUE the block SHALL drive mem_enable=1 and mem_addr=latched address, with mem_write_enable and mem_data_in depending on the request:
- Load or sub-word store: mem_write_enable=0.
- Word store: mem_write_enable=1, mem_data_in=wdata.
- Next state: MERGE for a sub-word store, RESP otherwise.
REQ-010 In MERGE the block SHALL drive mem_enable=1, mem_write_enable=1 and mem_addr=latched address, with mem_data_in merged into the current mem_data_out word:
- Byte store: {wdata[7:0], mem_data_out[23:0]}.
- Half store: {wdata[15:0], mem_data_out[15:0]}.
- Transition: MERGE -> RESP.
REQ-011 In RESP the block SHALL pulse resp_valid for the latched requester only.
- resp_rdata for loads: byte {24'b0, mem_data_out[31:24]}, half {16'b0, mem_data_out[31:16]}, word mem_data_out.
- resp_rdata for stores: 0.
- Transition: RESP -> IDLE.
REQ-012 Latency from the acceptance cycle T SHALL be: load and word store, resp_valid at T+2; sub-word store, resp_valid at T+3.
- No acceptance SHALL occur outside IDLE, so minimum request spacing is 3 cycles (4 for sub-word stores).
REQ-013 The memory read data SHALL be sampled on fixed one-cycle timing; mem_data_out_v SHALL NOT gate progress and is used only by bench assertions.
REQ-014 Addresses SHALL pass through unmodified, with no alignment check.
REQ-015 mem_enable SHALL be 0 in IDLE and RESP; resp_valid and req_ready SHALL never be high for both requesters in the same cycle.
REQ-016 A requester SHALL hold its request stable while valid and not ready; deasserting req_valid before ready drops the request with no response.

Reset
REQ-017 With rst high at a clock edge, the block SHALL set state=IDLE and last-grant=1, and SHALL zero all latched request fields.
REQ-018 During and after reset, all outputs SHALL be 0 until the next acceptance.
REQ-019 Reset in ISSUE, MERGE or RESP SHALL abort the transaction with no resp_valid.
- A memory write issued before the reset edge is not undone.
- During MERGE, the clock edge on which rst is sampled still writes mem_data_in to memory.

Verification
REQ-020 Word store then load: req0 stores 0xDEADBEEF at 0x100, then loads 0x100 -> store resp_valid_0 at T+2; load resp_rdata_0=0xDEADBEEF at T+2.
REQ-021 Sub-word RMW: memory 0x200=0x11223344; req1 stores byte 0xAA at 0x200 (wdata 0x000000AA), then loads word 0x200 -> 0xAA223344; a half store of 0xBBCC gives 0xBBCC3344; a byte load of 0x200 returns 0x000000BB.
REQ-022 Contention: both requesters continuously valid with loads for 6 transactions -> grants alternate 0,1,0,1,0,1; with RR_ENABLE=0, all six go to 0.
REQ-023 Isolation: the req1 response never raises resp_valid_0, and only one req_ready is high per acceptance cycle; checked over 1000 random mixed requests against a byte-array reference model.
REQ-024 Reset mid-RMW: rst asserted in the MERGE cycle -> no resp_valid; block in IDLE next cycle with all outputs 0; the next request completes normally with req0 winning contention.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter onto a single big-endian word memory. Loads and word stores
// take one memory cycle; byte/half stores are done as a read-modify-write.
module mem_arbiter #(
    parameter int RR_ENABLE = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic        req_we_0,
    input  logic [1:0]  req_size_0,
    input  logic [31:0] req_addr_0,
    input  logic [31:0] req_wdata_0,
    output logic        resp_valid_0,
    output logic [31:0] resp_rdata_0,

    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic        req_we_1,
    input  logic [1:0]  req_size_1,
    input  logic [31:0] req_addr_1,
    input  logic [31:0] req_wdata_1,
    output logic        resp_valid_1,
    output logic [31:0] resp_rdata_1,

    output logic        mem_enable,
    output logic [31:0] mem_addr,
    output logic        mem_write_enable,
    output logic [31:0] mem_data_in,
    input  logic        mem_data_out_v,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, MERGE, RESP} state_t;

    state_t      state, state_nxt;
    logic        last_grant;
    logic        grant_any, grant_id;
    logic        l_id, l_we;
    logic [1:0]  l_size;
    logic [31:0] l_addr, l_wdata;
    logic [31:0] rdata;

    // Round-robin favours the requester that lost the previous acceptance.
    always_comb begin
        grant_any = req_valid_0 | req_valid_1;
        if (req_valid_0 && req_valid_1)
            grant_id = (RR_ENABLE != 0) ? ~last_grant : 1'b0;
        else
            grant_id = req_valid_1;
    end

    always_comb begin
        state_nxt        = state;
        req_ready_0      = 1'b0;
        req_ready_1      = 1'b0;
        resp_valid_0     = 1'b0;
        resp_valid_1     = 1'b0;
        resp_rdata_0     = '0;
        resp_rdata_1     = '0;
        mem_enable       = 1'b0;
        mem_addr         = '0;
        mem_write_enable = 1'b0;
        mem_data_in      = '0;
        rdata            = '0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    req_ready_0 = ~grant_id;
                    req_ready_1 = grant_id;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                mem_enable = 1'b1;
                mem_addr   = l_addr;
                if (l_we && l_size[1]) begin
                    mem_write_enable = 1'b1;
                    mem_data_in      = l_wdata;
                end
                state_nxt = (l_we && !l_size[1]) ? MERGE : RESP;
            end
            MERGE: begin
                // Sub-word lands in the most significant (lowest address) bytes.
                mem_enable       = 1'b1;
                mem_write_enable = 1'b1;
                mem_addr         = l_addr;
                mem_data_in      = l_size[0] ? {l_wdata[15:0], mem_data_out[15:0]}
                                             : {l_wdata[7:0], mem_data_out[23:0]};
                state_nxt        = RESP;
            end
            RESP: begin
                if (!l_we) begin
                    case (l_size)
                        2'b00:   rdata = {24'h0, mem_data_out[31:24]};
                        2'b01:   rdata = {16'h0, mem_data_out[31:16]};
                        default: rdata = mem_data_out;
                    endcase
                end
                resp_valid_0 = ~l_id;
                resp_valid_1 = l_id;
                resp_rdata_0 = l_id ? 32'h0 : rdata;
                resp_rdata_1 = l_id ? rdata : 32'h0;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            l_id       <= 1'b0;
            l_we       <= 1'b0;
            l_size     <= '0;
            l_addr     <= '0;
            l_wdata    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_any) begin
                last_grant <= grant_id;
                l_id       <= grant_id;
                l_we       <= grant_id ? req_we_1    : req_we_0;
                l_size     <= grant_id ? req_size_1  : req_size_0;
                l_addr     <= grant_id ? req_addr_1  : req_addr_0;
                l_wdata    <= grant_id ? req_wdata_1 : req_wdata_0;
            end
            // Read data is taken on fixed timing; the memory must have it ready.
            if (state == MERGE || (state == RESP && !l_we))
                assert (mem_data_out_v);
        end
    end

endmodule
